tdm_demux_1to4: RTL and testbench



---
 rtl/tdm_demux_pkg.sv | 21 ++
 rtl/tdm_slot_ctr.sv | 33 +++
 rtl/tdm_demux_1to4.sv | 127 ++++++++++++
 tb/tb_tdm_demux_1to4.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_demux_pkg.sv
// Shared types and constants for the 1:4 TDM demultiplexer.
// State and slot encodings are plain localparams so legacy code can reuse them.
package tdm_demux_pkg;

  localparam int unsigned NUM_SLOTS = 4;

  typedef logic [0:0] state_t;
  localparam state_t StHunt = 1'b0;
  localparam state_t StLock = 1'b1;

  typedef logic [$clog2(NUM_SLOTS)-1:0] slot_t;
  localparam slot_t SLOT_A = 2'd0;
  localparam slot_t SLOT_B = 2'd1;
  localparam slot_t SLOT_C = 2'd2;
  localparam slot_t SLOT_D = 2'd3;

  function automatic logic is_last_slot(input slot_t s);
    return s == SLOT_D;
  endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// 2-bit wrapping slot counter; load forces slot b so a sync sample can be taken as slot a.
module tdm_slot_ctr
  import tdm_demux_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en,
  input  logic  load,
  output slot_t slot
);

  slot_t slot_q, slot_d;

  always_comb begin
    slot_d = slot_q;
    if (load) begin
      slot_d = SLOT_B;
    end else if (en) begin
      slot_d = slot_q + slot_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q <= SLOT_A;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot = slot_q;

endmodule

// File: rtl/tdm_demux_1to4.sv
// 1:4 TDM demultiplexer: aligns on frame_sync at slot a and emits whole frames on valid.
// Optional misplaced-sync detection and realignment: define TDM_DEMUX_SYNC_CHECK_EN.
module tdm_demux_1to4
  import tdm_demux_pkg::*;
#(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  input  logic         frame_sync,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic [W-1:0] c,
  output logic [W-1:0] d,
  output logic         valid,
  output logic         sync_err
);

  state_t       state_q, state_d;
  slot_t        slot;
  logic         ctr_en, ctr_load;
  logic [W-1:0] sh_a_q, sh_a_d, sh_b_q, sh_b_d, sh_c_q, sh_c_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic         valid_q, valid_d, sync_err_q, sync_err_d;
  logic         misplaced;

`ifdef TDM_DEMUX_SYNC_CHECK_EN
  assign misplaced = (state_q == StLock) && din_valid && frame_sync && (slot != SLOT_A);
`else
  assign misplaced = 1'b0;
`endif

  tdm_slot_ctr u_slot_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ctr_en),
    .load  (ctr_load),
    .slot  (slot)
  );

  always_comb begin
    state_d    = state_q;
    ctr_en     = 1'b0;
    ctr_load   = 1'b0;
    sh_a_d     = sh_a_q;
    sh_b_d     = sh_b_q;
    sh_c_d     = sh_c_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    d_d        = d_q;
    valid_d    = 1'b0;
    sync_err_d = 1'b0;

    case (state_q)
      StHunt: begin
        if (din_valid && frame_sync) begin
          sh_a_d   = din;
          ctr_load = 1'b1;
          state_d  = StLock;
        end
      end
      StLock: begin
        if (din_valid) begin
          if (misplaced) begin
            // Drop the partial frame and treat this sample as a fresh slot a.
            sync_err_d = 1'b1;
            sh_a_d     = din;
            ctr_load   = 1'b1;
          end else if (is_last_slot(slot)) begin
            a_d     = sh_a_q;
            b_d     = sh_b_q;
            c_d     = sh_c_q;
            d_d     = din;
            valid_d = 1'b1;
            ctr_en  = 1'b1;
          end else begin
            case (slot)
              SLOT_A:  sh_a_d = din;
              SLOT_B:  sh_b_d = din;
              SLOT_C:  sh_c_d = din;
              default: sh_a_d = sh_a_q;
            endcase
            ctr_en = 1'b1;
          end
        end
      end
      default: state_d = StHunt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StHunt;
      sh_a_q     <= '0;
      sh_b_q     <= '0;
      sh_c_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      d_q        <= '0;
      valid_q    <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_a_q     <= sh_a_d;
      sh_b_q     <= sh_b_d;
      sh_c_q     <= sh_c_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      d_q        <= d_d;
      valid_q    <= valid_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign a        = a_q;
  assign b        = b_q;
  assign c        = c_q;
  assign d        = d_q;
  assign valid    = valid_q;
  assign sync_err = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// Bench for tdm_demux_1to4: queue-based frame model compared every cycle, plus directed checks.
module tb_tdm_demux_1to4;

`ifdef TDM_DEMUX_SYNC_CHECK_EN
  localparam bit SyncCheck = 1'b1;
`else
  localparam bit SyncCheck = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] din = '0;
  logic       din_valid = 1'b0;
  logic       frame_sync = 1'b0;
  logic [3:0] a, b, c, d;
  logic       valid, sync_err;

  int errors = 0;
  int checks = 0;

  tdm_demux_1to4 #(.W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .a          (a),
    .b          (b),
    .c          (c),
    .d          (d),
    .valid      (valid),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  // Model: locked flag plus a queue of samples collected for the frame in progress.
  bit         m_lock = 1'b0;
  logic [3:0] m_frame[$];
  logic [3:0] m_out[4] = '{4'd0, 4'd0, 4'd0, 4'd0};
  bit         m_valid = 1'b0;
  bit         m_err = 1'b0;
  bit         started = 1'b0;
  int         cyc = 0;

  always @(posedge clk) begin
    m_valid = 1'b0;
    m_err   = 1'b0;
    cyc     = cyc + 1;
    if (!rst_n) begin
      started = 1'b1;
      m_lock  = 1'b0;
      m_frame.delete();
      for (int i = 0; i < 4; i++) m_out[i] = 4'd0;
    end else if (din_valid) begin
      if (!m_lock) begin
        if (frame_sync) begin
          m_lock = 1'b1;
          m_frame.delete();
          m_frame.push_back(din);
        end
      end else if (SyncCheck && frame_sync && m_frame.size() != 0) begin
        m_err = 1'b1;
        m_frame.delete();
        m_frame.push_back(din);
      end else begin
        m_frame.push_back(din);
        if (m_frame.size() == 4) begin
          for (int i = 0; i < 4; i++) m_out[i] = m_frame[i];
          m_valid = 1'b1;
          m_frame.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      checks++;
      if ({a, b, c, d, valid, sync_err} !==
          {m_out[0], m_out[1], m_out[2], m_out[3], m_valid, m_err}) begin
        errors++;
        $display("FAIL model cycle %0d: got a=%h b=%h c=%h d=%h v=%b e=%b, want a=%h b=%h c=%h d=%h v=%b e=%b",
                 cyc, a, b, c, d, valid, sync_err,
                 m_out[0], m_out[1], m_out[2], m_out[3], m_valid, m_err);
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic drive(input logic [3:0] dv, input bit v, input bit s);
    @(negedge clk);
    din        = dv;
    din_valid  = v;
    frame_sync = s;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n     = 1'b0;
    din_valid = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset with random activity on the inputs.
    repeat (3) begin
      @(negedge clk);
      rst_n      = 1'b0;
      din        = 4'($urandom);
      din_valid  = 1'($urandom);
      frame_sync = 1'($urandom);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    din_valid = 1'b0;
    chk("reset_abcd", {a, b, c, d}, 16'h0000);
    chk("reset_valid", 16'(valid), 16'h0);
    chk("reset_err", 16'(sync_err), 16'h0);

    // Hunting: qualified data without sync is ignored.
    repeat (6) drive(4'($urandom), 1'b1, 1'b0);
    drive(4'h0, 1'b0, 1'b0);
    chk("hunt_valid", 16'(valid), 16'h0);
    chk("hunt_abcd", {a, b, c, d}, 16'h0000);

    // Basic frame.
    do_reset(1);
    drive(4'h1, 1'b1, 1'b1);
    drive(4'h2, 1'b1, 1'b0);
    drive(4'h3, 1'b1, 1'b0);
    drive(4'h4, 1'b1, 1'b0);
    drive(4'h0, 1'b0, 1'b0);
    chk("basic_valid", 16'(valid), 16'h1);
    chk("basic_abcd", {a, b, c, d}, 16'h1234);
    drive(4'h0, 1'b0, 1'b0);
    chk("basic_pulse", 16'(valid), 16'h0);
    chk("basic_hold", {a, b, c, d}, 16'h1234);

    // Back-to-back frames, gap inside the second frame.
    drive(4'h5, 1'b1, 1'b1);
    drive(4'h6, 1'b1, 1'b0);
    drive(4'h7, 1'b1, 1'b0);
    drive(4'h8, 1'b1, 1'b0);
    drive(4'h9, 1'b1, 1'b1);
    chk("b2b_valid1", 16'(valid), 16'h1);
    chk("b2b_abcd1", {a, b, c, d}, 16'h5678);
    drive(4'hA, 1'b1, 1'b0);
    chk("b2b_novalid", 16'(valid), 16'h0);
    drive(4'hF, 1'b0, 1'b1);
    drive(4'hE, 1'b0, 1'b0);
    chk("gap_hold", {a, b, c, d}, 16'h5678);
    drive(4'hB, 1'b1, 1'b0);
    drive(4'hC, 1'b1, 1'b0);
    drive(4'h0, 1'b0, 1'b0);
    chk("b2b_valid2", 16'(valid), 16'h1);
    chk("b2b_abcd2", {a, b, c, d}, 16'h9ABC);

    // Misplaced sync at slot c.
    do_reset(1);
    drive(4'h1, 1'b1, 1'b1);
    drive(4'h2, 1'b1, 1'b0);
    drive(4'h3, 1'b1, 1'b1);
    drive(4'h4, 1'b1, 1'b0);
    chk("mis_err", 16'(sync_err), 16'(SyncCheck));
    drive(4'h5, 1'b1, 1'b0);
    chk("mis_err_pulse", 16'(sync_err), 16'h0);
    chk("mis_valid_first", 16'(valid), 16'(!SyncCheck));
    if (!SyncCheck) chk("mis_abcd_nochk", {a, b, c, d}, 16'h1234);
    drive(4'h6, 1'b1, 1'b0);
    drive(4'h0, 1'b0, 1'b0);
    chk("mis_valid_second", 16'(valid), 16'(SyncCheck));
    chk("mis_abcd", {a, b, c, d}, SyncCheck ? 16'h3456 : 16'h1234);
    drive(4'h0, 1'b0, 1'b0);
    chk("mis_tail", 16'(valid), 16'h0);

    // Reset mid-frame discards the partial frame.
    do_reset(1);
    drive(4'h1, 1'b1, 1'b1);
    drive(4'h2, 1'b1, 1'b0);
    @(negedge clk);
    rst_n     = 1'b0;
    din_valid = 1'b0;
    drive(4'h3, 1'b1, 1'b0);
    rst_n = 1'b1;
    drive(4'h4, 1'b1, 1'b0);
    drive(4'h0, 1'b0, 1'b0);
    chk("rmf_valid", 16'(valid), 16'h0);
    chk("rmf_abcd", {a, b, c, d}, 16'h0000);
    drive(4'h7, 1'b1, 1'b1);
    drive(4'h8, 1'b1, 1'b0);
    drive(4'h9, 1'b1, 1'b0);
    drive(4'hA, 1'b1, 1'b0);
    drive(4'h0, 1'b0, 1'b0);
    chk("rmf_recover", {a, b, c, d}, 16'h789A);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst_n      = ($urandom_range(199) != 0);
      din        = 4'($urandom);
      din_valid  = ($urandom_range(3) != 0);
      frame_sync = ($urandom_range(5) == 0);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    din_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
